word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_if.sv | 36 +++
 rtl/word_serializer.sv | 134 +++++++++++++
 tb/tb_word_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/word_serializer_if.sv
// Word serializer bus: parallel word handshake in, serial bit stream out.
//   data_in      producer -> serializer  parallel word (WIDTH bits)
//   data_valid   producer -> serializer  data_in holds a word
//   data_ready   serializer -> producer  word can be accepted this cycle
//   sequence_out serializer -> consumer  serial bit, MSB first
//   bit_valid    serializer -> consumer  sequence_out carries a frame bit
//   word_done    serializer -> consumer  pulse on the final frame bit
// Modports: slave = serializer side, master = producer/consumer side.
interface word_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             sequence_out;
  logic             bit_valid;
  logic             word_done;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  sequence_out,
    input  bit_valid,
    input  word_done
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output sequence_out,
    output bit_valid,
    output word_done
  );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial word serializer, MSB first, with a valid/ready input handshake.
// A word accepted on edge N shows its MSB in the cycle after edge N. Frames run back to back
// when a new word is offered on the final frame bit.
// Optional feature macro: SER_PARITY_EN -- appends one even-parity bit per frame.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   ser_if  word_serializer_if.slave (data_in/data_valid in, data_ready, sequence_out,
//           bit_valid, word_done out)
module word_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clock,
  input logic                reset,
  word_serializer_if.slave   ser_if
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_bit;
  logic              accept;

`ifdef SER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);
  assign accept   = ser_if.data_valid && ser_if.data_ready;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (last_bit) begin
`ifdef SER_PARITY_EN
          state_d = StParity;
`else
          state_d = accept ? StShift : StIdle;
`endif
        end
      end
`ifdef SER_PARITY_EN
      StParity: begin
        state_d = accept ? StShift : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; a new load wins over the final shift for gapless frames
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shift_d = ser_if.data_in;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      shift_d = shift_q << 1;
      cnt_d   = cnt_q + CntW'(1);
    end
  end

`ifdef SER_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (accept) parity_d = ^ser_if.data_in;
  end
`endif

  // Outputs; data_ready is gated by reset so nothing is offered while reset is held
  always_comb begin
    ser_if.sequence_out = 1'b0;
    ser_if.bit_valid    = 1'b0;
    ser_if.word_done    = 1'b0;
    ser_if.data_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ser_if.data_ready = !reset;
      end
      StShift: begin
        ser_if.sequence_out = shift_q[WIDTH-1];
        ser_if.bit_valid    = 1'b1;
`ifndef SER_PARITY_EN
        ser_if.word_done    = last_bit;
        ser_if.data_ready   = last_bit && !reset;
`endif
      end
`ifdef SER_PARITY_EN
      StParity: begin
        ser_if.sequence_out = parity_q;
        ser_if.bit_valid    = 1'b1;
        ser_if.word_done    = 1'b1;
        ser_if.data_ready   = !reset;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (WIDTH=8). Cycle-level vector table plus
// hand-written sequences for reset, mid-frame abort and idle. Handles SER_PARITY_EN.
module tb_word_serializer;
  localparam int unsigned WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif

  logic clock = 1'b0;
  logic reset;

  word_serializer_if #(.WIDTH(WIDTH)) bus ();

  word_serializer #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .ser_if (bus.slave)
  );

  always #5 clock = ~clock;

  // exp = {data_ready, sequence_out, bit_valid, word_done}
  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic dv, input logic [7:0] din, input logic [3:0] exp);
    vec_t v;
    v.dv  = dv;
    v.din = din;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.data_ready, bus.sequence_out, bus.bit_valid, bus.word_done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rdy/so/bv/wd got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then settle before sampling
  task automatic step(input logic dv, input logic [7:0] din);
    @(negedge clock);
    bus.data_valid = dv;
    bus.data_in    = din;
    #1;
  endtask

  initial begin
    logic [7:0] w;
    logic       ebit;
    logic [3:0] e;

    // Frame B0 with stall at bit 3 and junk on data_in, then back-to-back 0B
    add(1'b1, 8'hB0, 4'b1000);
    add(1'b0, 8'h00, 4'b0110);
    add(1'b0, 8'h55, 4'b0010);
    add(1'b1, 8'hFF, 4'b0110); // offered while not ready: ignored
    add(1'b0, 8'hFF, 4'b0110);
    add(1'b0, 8'h00, 4'b0010);
    add(1'b0, 8'h00, 4'b0010);
    add(1'b0, 8'h00, 4'b0010);
`ifdef SER_PARITY_EN
    add(1'b1, 8'h00, 4'b0010); // last data bit, not ready yet
    add(1'b1, 8'h00, 4'b1111); // parity of B0 = 1, accepts 00
    for (int i = 0; i < 8; i++) add(1'b0, 8'hA5, 4'b0010);
    add(1'b0, 8'h00, 4'b1011); // parity of 00 = 0
    add(1'b0, 8'h00, 4'b1000);
`else
    add(1'b1, 8'h0B, 4'b1011); // last bit of B0, accepts 0B
    add(1'b0, 8'h0B, 4'b0010);
    add(1'b0, 8'h0B, 4'b0010);
    add(1'b0, 8'h0B, 4'b0010);
    add(1'b0, 8'h0B, 4'b0010);
    add(1'b0, 8'h0B, 4'b0110);
    add(1'b0, 8'h0B, 4'b0010);
    add(1'b0, 8'h0B, 4'b0110);
    add(1'b0, 8'h00, 4'b1111);
    add(1'b0, 8'h00, 4'b1000);
`endif

    bus.data_valid = 1'b1;
    bus.data_in    = 8'hC3;
    reset          = 1'b1;
    #1;
    check("reset_outputs", 4'b0000);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held_valid", 4'b0000);
    @(negedge clock);
    bus.data_valid = 1'b0;
    reset          = 1'b0;
    #1;
    check("post_reset_ready", 4'b1000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].dv, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Idle with data_valid low
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'($urandom));
      check($sformatf("idle%0d", i), 4'b1000);
    end

    // Reset mid-frame after 3 bits of B0
    step(1'b1, 8'hB0);
    check("abort_accept", 4'b1000);
    step(1'b0, 8'h00);
    check("abort_bit1", 4'b0110);
    step(1'b0, 8'h00);
    check("abort_bit2", 4'b0010);
    step(1'b0, 8'h00);
    check("abort_bit3", 4'b0110);
    #1;
    reset = 1'b1;
    #1;
    check("abort_immediate", 4'b0000);
    @(posedge clock);
    #1;
    check("abort_held", 4'b0000);
    @(negedge clock);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h80;
    reset          = 1'b0;
    #1;
    check("abort_release_ready", 4'b1000);

    // Frame 80 after release: starts from its MSB
    w = 8'h80;
    for (int k = 0; k < FrameLen; k++) begin
      step(1'b0, 8'h00);
      ebit = (k < WIDTH) ? w[WIDTH-1-k] : ^w;
      e = {k == FrameLen - 1, ebit, 1'b1, k == FrameLen - 1};
      check($sformatf("frame80_bit%0d", k), e);
    end
    step(1'b0, 8'h00);
    check("frame80_idle", 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
